// File: rtl/hyperbus_phy_dispatch_if.sv
// Handshake bundle between the AXI frontend, the multi-PHY dispatcher and
// the per-PHY channels. "slave" is the dispatcher view, "master" the environment.
interface hyperbus_phy_dispatch_if #(
    parameter int NumChips   = 2,
    parameter int NumPhys    = 2,
    parameter int BeatWidth  = 8,
    parameter int TransWidth = 32,
    parameter int TxWidth    = 16,
    parameter int RxWidth    = 16,
    parameter int BWidth     = 4
);
    localparam int CsPerPhy = NumChips / NumPhys;

    logic [TransWidth-1:0] trans_i;
    logic                  trans_write_i;
    logic [BeatWidth-1:0]  trans_beats_i;
    logic [NumChips-1:0]   trans_cs_i;
    logic                  trans_valid_i;
    logic                  trans_ready_o;

    logic [TxWidth-1:0]    tx_i;
    logic                  tx_valid_i;
    logic                  tx_ready_o;

    logic [RxWidth-1:0]    rx_o;
    logic                  rx_last_o;
    logic                  rx_valid_o;
    logic                  rx_ready_i;

    logic [BWidth-1:0]     b_o;
    logic                  b_valid_o;
    logic                  b_ready_i;

    logic [TransWidth-1:0]               phy_trans_o;
    logic [NumPhys-1:0][CsPerPhy-1:0]    phy_trans_cs_o;
    logic [NumPhys-1:0]                  phy_trans_valid_o;
    logic [NumPhys-1:0]                  phy_trans_ready_i;

    logic [TxWidth-1:0]    phy_tx_o;
    logic [NumPhys-1:0]    phy_tx_valid_o;
    logic [NumPhys-1:0]    phy_tx_ready_i;

    logic [NumPhys-1:0][RxWidth-1:0] phy_rx_i;
    logic [NumPhys-1:0]              phy_rx_last_i;
    logic [NumPhys-1:0]              phy_rx_valid_i;
    logic [NumPhys-1:0]              phy_rx_ready_o;

    logic [NumPhys-1:0][BWidth-1:0]  phy_b_i;
    logic [NumPhys-1:0]              phy_b_valid_i;
    logic [NumPhys-1:0]              phy_b_ready_o;

    logic idle_o;

    modport slave (
        input  trans_i, trans_write_i, trans_beats_i, trans_cs_i,
        input  trans_valid_i,
        output trans_ready_o,
        input  tx_i, tx_valid_i,
        output tx_ready_o,
        output rx_o, rx_last_o, rx_valid_o,
        input  rx_ready_i,
        output b_o, b_valid_o,
        input  b_ready_i,
        output phy_trans_o, phy_trans_cs_o, phy_trans_valid_o,
        input  phy_trans_ready_i,
        output phy_tx_o, phy_tx_valid_o,
        input  phy_tx_ready_i,
        input  phy_rx_i, phy_rx_last_i, phy_rx_valid_i,
        output phy_rx_ready_o,
        input  phy_b_i, phy_b_valid_i,
        output phy_b_ready_o,
        output idle_o
    );

    modport master (
        output trans_i, trans_write_i, trans_beats_i, trans_cs_i,
        output trans_valid_i,
        input  trans_ready_o,
        output tx_i, tx_valid_i,
        input  tx_ready_o,
        input  rx_o, rx_last_o, rx_valid_o,
        output rx_ready_i,
        input  b_o, b_valid_o,
        output b_ready_i,
        input  phy_trans_o, phy_trans_cs_o, phy_trans_valid_o,
        output phy_trans_ready_i,
        input  phy_tx_o, phy_tx_valid_o,
        output phy_tx_ready_i,
        output phy_rx_i, phy_rx_last_i, phy_rx_valid_i,
        input  phy_rx_ready_o,
        output phy_b_i, phy_b_valid_i,
        input  phy_b_ready_o,
        input  idle_o
    );
endinterface

// File: rtl/hyperbus_phy_dispatch.sv
// Routes HyperBus transfers to the PHY owning the addressed chip and uses
// per-direction order FIFOs to merge TX/RX/B beats back into one in-order stream.
// Ports: clk_i, rst_ni (async active-low), bus (frontend + PHY handshakes, idle).
module hyperbus_phy_dispatch #(
    parameter int NumChips  = 2,
    parameter int NumPhys   = 2,
    parameter int MaxTxns   = 4,
    parameter int BeatWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    hyperbus_phy_dispatch_if.slave bus
);
    localparam int CsPerPhy = NumChips / NumPhys;
    localparam int PhyW     = (NumPhys > 1) ? $clog2(NumPhys) : 1;
    localparam int ChipW    = (NumChips > 1) ? $clog2(NumChips) : 1;
    localparam int PtrW     = $clog2(MaxTxns);
    localparam int CntW     = PtrW + 1;

    typedef logic [PhyW-1:0]      phy_t;
    typedef logic [PtrW-1:0]      ptr_t;
    typedef logic [CntW-1:0]      cnt_t;
    typedef logic [BeatWidth-1:0] beats_t;

    logic [MaxTxns-1:0][PhyW-1:0]      w_phy_q;
    logic [MaxTxns-1:0][BeatWidth-1:0] w_beats_q;
    logic [MaxTxns-1:0][PhyW-1:0]      b_phy_q;
    logic [MaxTxns-1:0][PhyW-1:0]      r_phy_q;

    ptr_t w_wr, w_rd, b_wr, b_rd, r_wr, r_rd;
    cnt_t w_cnt, b_cnt, r_cnt;

    beats_t tx_cnt;
    logic   tx_active;

    logic [ChipW-1:0] sel_chip;
    phy_t sel_phy;
    logic space, accept;
    logic w_push, w_pop, b_push, b_pop, r_push, r_pop;
    logic w_full, b_full, r_full;
    logic w_empty, b_empty, r_empty;
    phy_t w_head, b_head, r_head;
    beats_t tx_rem;
    logic tx_fire;

    // Lowest set chip select wins; no select falls back to chip 0.
    always_comb begin
        sel_chip = '0;
        for (int c = NumChips - 1; c >= 0; c--) begin
            if (bus.trans_cs_i[c]) sel_chip = ChipW'(c);
        end
    end

    assign sel_phy = PhyW'(int'(sel_chip) / CsPerPhy);

    assign w_full  = (w_cnt == cnt_t'(MaxTxns));
    assign b_full  = (b_cnt == cnt_t'(MaxTxns));
    assign r_full  = (r_cnt == cnt_t'(MaxTxns));
    assign w_empty = (w_cnt == '0);
    assign b_empty = (b_cnt == '0);
    assign r_empty = (r_cnt == '0);

    // Space uses the registered fill level: a same-cycle pop does not help.
    assign space = bus.trans_write_i ? (!w_full && !b_full) : !r_full;

    always_comb begin
        bus.phy_trans_valid_o = '0;
        bus.phy_trans_cs_o    = '0;
        bus.phy_trans_valid_o[sel_phy] = bus.trans_valid_i && space;
        bus.phy_trans_cs_o[sel_phy] =
            bus.trans_cs_i[int'(sel_phy) * CsPerPhy +: CsPerPhy];
    end

    assign bus.phy_trans_o   = bus.trans_i;
    assign bus.trans_ready_o = bus.phy_trans_ready_i[sel_phy] && space;

    assign accept = bus.trans_valid_i && bus.trans_ready_o;
    assign w_push = accept && bus.trans_write_i;
    assign b_push = w_push;
    assign r_push = accept && !bus.trans_write_i;

    // TX path: W head owns the stream until its last beat is taken.
    assign w_head = w_phy_q[w_rd];
    assign tx_rem = tx_active ? tx_cnt : w_beats_q[w_rd];

    always_comb begin
        bus.phy_tx_valid_o = '0;
        if (!w_empty) bus.phy_tx_valid_o[w_head] = bus.tx_valid_i;
    end

    assign bus.phy_tx_o   = bus.tx_i;
    assign bus.tx_ready_o = !w_empty && bus.phy_tx_ready_i[w_head];
    assign tx_fire        = bus.tx_valid_i && bus.tx_ready_o;
    assign w_pop          = tx_fire && (tx_rem == '0);

    // RX path: R head selects the source; other PHYs are held off.
    assign r_head         = r_phy_q[r_rd];
    assign bus.rx_o       = bus.phy_rx_i[r_head];
    assign bus.rx_last_o  = bus.phy_rx_last_i[r_head];
    assign bus.rx_valid_o = !r_empty && bus.phy_rx_valid_i[r_head];

    always_comb begin
        bus.phy_rx_ready_o = '0;
        if (!r_empty) bus.phy_rx_ready_o[r_head] = bus.rx_ready_i;
    end

    assign r_pop = bus.rx_valid_o && bus.rx_ready_i && bus.rx_last_o;

    // B path: one response per write, strictly in issue order.
    assign b_head        = b_phy_q[b_rd];
    assign bus.b_o       = bus.phy_b_i[b_head];
    assign bus.b_valid_o = !b_empty && bus.phy_b_valid_i[b_head];

    always_comb begin
        bus.phy_b_ready_o = '0;
        if (!b_empty) bus.phy_b_ready_o[b_head] = bus.b_ready_i;
    end

    assign b_pop = bus.b_valid_o && bus.b_ready_i;

    assign bus.idle_o = w_empty && b_empty && r_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_phy_q   <= '0;
            w_beats_q <= '0;
            b_phy_q   <= '0;
            r_phy_q   <= '0;
            w_wr      <= '0;
            w_rd      <= '0;
            b_wr      <= '0;
            b_rd      <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            w_cnt     <= '0;
            b_cnt     <= '0;
            r_cnt     <= '0;
            tx_cnt    <= '0;
            tx_active <= 1'b0;
        end else begin
            if (w_push) begin
                w_phy_q[w_wr]   <= sel_phy;
                w_beats_q[w_wr] <= bus.trans_beats_i;
                w_wr            <= w_wr + ptr_t'(1);
            end
            if (w_pop) w_rd <= w_rd + ptr_t'(1);
            w_cnt <= w_cnt + cnt_t'(w_push) - cnt_t'(w_pop);

            if (b_push) begin
                b_phy_q[b_wr] <= sel_phy;
                b_wr          <= b_wr + ptr_t'(1);
            end
            if (b_pop) b_rd <= b_rd + ptr_t'(1);
            b_cnt <= b_cnt + cnt_t'(b_push) - cnt_t'(b_pop);

            if (r_push) begin
                r_phy_q[r_wr] <= sel_phy;
                r_wr          <= r_wr + ptr_t'(1);
            end
            if (r_pop) r_rd <= r_rd + ptr_t'(1);
            r_cnt <= r_cnt + cnt_t'(r_push) - cnt_t'(r_pop);

            // Counter is loaded from the head on the first beat of a burst.
            if (w_pop) begin
                tx_active <= 1'b0;
                tx_cnt    <= '0;
            end else if (tx_fire) begin
                tx_active <= 1'b1;
                tx_cnt    <= tx_rem - beats_t'(1);
            end
        end
    end
endmodule

// File: tb/tb_hyperbus_phy_dispatch.sv
// Directed scoreboard bench for hyperbus_phy_dispatch.
// Expected RX/TX/B beats are queued at issue time and popped as the DUT emits them.
module tb_hyperbus_phy_dispatch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hyperbus_phy_dispatch_if bus ();

    hyperbus_phy_dispatch dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [16:0] rx_q[$];
    logic [16:0] tx_q[$];
    logic [3:0]  b_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic quiet();
        bus.trans_i           = '0;
        bus.trans_write_i     = 1'b0;
        bus.trans_beats_i     = '0;
        bus.trans_cs_i        = '0;
        bus.trans_valid_i     = 1'b0;
        bus.tx_i              = '0;
        bus.tx_valid_i        = 1'b0;
        bus.rx_ready_i        = 1'b1;
        bus.b_ready_i         = 1'b1;
        bus.phy_trans_ready_i = 2'b11;
        bus.phy_tx_ready_i    = 2'b11;
        bus.phy_rx_i          = '0;
        bus.phy_rx_last_i     = '0;
        bus.phy_rx_valid_i    = '0;
        bus.phy_b_i           = '0;
        bus.phy_b_valid_i     = '0;
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_idle"}, bus.idle_o, 1);
        check({tag, "_tx_ready"}, bus.tx_ready_o, 0);
        check({tag, "_rx_valid"}, bus.rx_valid_o, 0);
        check({tag, "_b_valid"}, bus.b_valid_o, 0);
        check({tag, "_phy_tx_valid"}, bus.phy_tx_valid_o, 0);
        check({tag, "_phy_rx_ready"}, bus.phy_rx_ready_o, 0);
        check({tag, "_phy_b_ready"}, bus.phy_b_ready_o, 0);
    endtask

    task automatic issue(input logic wr, input logic [1:0] cs,
                         input logic [7:0] beats);
        bus.trans_i       = {24'h5A5A00, beats};
        bus.trans_write_i = wr;
        bus.trans_cs_i    = cs;
        bus.trans_beats_i = beats;
        bus.trans_valid_i = 1'b1;
    endtask

    task automatic rx_beat(input int phy, input logic [15:0] data,
                           input logic last, input string tag);
        logic [16:0] e;
        bus.phy_rx_valid_i      = '0;
        bus.phy_rx_valid_i[phy] = 1'b1;
        bus.phy_rx_i[phy]       = data;
        bus.phy_rx_last_i[phy]  = last;
        settle();
        check({tag, "_rx_valid"}, bus.rx_valid_o, 1);
        check({tag, "_phy_rx_ready"}, bus.phy_rx_ready_o, 32'(1) << phy);
        if (rx_q.size() == 0) begin
            check({tag, "_rx_queue"}, 0, 1);
        end else begin
            e = rx_q.pop_front();
            check({tag, "_rx_data"}, bus.rx_o, e[15:0]);
            check({tag, "_rx_last"}, bus.rx_last_o, e[16]);
        end
    endtask

    task automatic tx_beat(input string tag);
        logic [16:0] e;
        if (tx_q.size() == 0) begin
            check({tag, "_tx_queue"}, 0, 1);
        end else begin
            e = tx_q.pop_front();
            bus.tx_i       = e[15:0];
            bus.tx_valid_i = 1'b1;
            settle();
            check({tag, "_tx_ready"}, bus.tx_ready_o, 1);
            check({tag, "_phy_tx_valid"}, bus.phy_tx_valid_o,
                  32'(1) << e[16]);
            check({tag, "_phy_tx_data"}, bus.phy_tx_o, e[15:0]);
        end
    endtask

    task automatic b_expect(input string tag);
        if (b_q.size() == 0) begin
            check({tag, "_b_queue"}, 0, 1);
        end else begin
            check({tag, "_b_valid"}, bus.b_valid_o, 1);
            check({tag, "_b_data"}, bus.b_o, b_q.pop_front());
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        tick();
        tick();
        check_quiet_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", bus.idle_o, 1);

        // Read on chip 1, 4 beats from PHY 1.
        issue(1'b0, 2'b10, 8'd3);
        settle();
        check("rd1_phy_valid", bus.phy_trans_valid_o, 2'b10);
        check("rd1_phy_cs", bus.phy_trans_cs_o, 2'b10);
        check("rd1_ready", bus.trans_ready_o, 1);
        for (int i = 0; i < 4; i++) rx_q.push_back({(i == 3), 16'hA100 + 16'(i)});
        tick();
        bus.trans_valid_i = 1'b0;
        settle();
        check("rd1_busy", bus.idle_o, 0);
        for (int i = 0; i < 4; i++) begin
            rx_beat(1, 16'hA100 + 16'(i), (i == 3), "rd1");
            tick();
        end
        quiet();
        settle();
        check("rd1_idle", bus.idle_o, 1);

        // Two writes to different PHYs, TX switch and in-order B.
        issue(1'b1, 2'b01, 8'd2);
        bus.tx_valid_i = 1'b1;
        settle();
        check("wr0_phy_valid", bus.phy_trans_valid_o, 2'b01);
        check("wr0_tx_blocked", bus.tx_ready_o, 0);
        check("wr0_tx_none", bus.phy_tx_valid_o, 0);
        for (int i = 0; i < 3; i++) tx_q.push_back({1'b0, 16'hB000 + 16'(i)});
        b_q.push_back(4'h3);
        tick();
        bus.tx_valid_i = 1'b0;
        issue(1'b1, 2'b10, 8'd0);
        settle();
        check("wr1_phy_valid", bus.phy_trans_valid_o, 2'b10);
        tx_q.push_back({1'b1, 16'hB100});
        b_q.push_back(4'hC);
        tick();
        bus.trans_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_beat("wr_tx");
            tick();
        end
        bus.tx_valid_i = 1'b0;
        bus.phy_b_i[0] = 4'h3;
        bus.phy_b_i[1] = 4'hC;
        bus.phy_b_valid_i = 2'b10;
        settle();
        check("b_stall_valid", bus.b_valid_o, 0);
        check("b_stall_ready", bus.phy_b_ready_o, 2'b01);
        tick();
        bus.phy_b_valid_i = 2'b11;
        settle();
        b_expect("b_first");
        tick();
        bus.phy_b_valid_i = 2'b10;
        settle();
        check("b_second_ready", bus.phy_b_ready_o, 2'b10);
        b_expect("b_second");
        tick();
        quiet();
        settle();
        check("wr_idle", bus.idle_o, 1);

        // Fill R with 4 reads, 5th blocked, writes still allowed.
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 2'b01, 8'd0);
            settle();
            check("fill_ready", bus.trans_ready_o, 1);
            rx_q.push_back({1'b1, 16'hC000 + 16'(i)});
            tick();
        end
        issue(1'b0, 2'b01, 8'd0);
        settle();
        check("full_ready", bus.trans_ready_o, 0);
        check("full_phy_valid", bus.phy_trans_valid_o, 0);
        issue(1'b1, 2'b10, 8'd0);
        settle();
        check("full_wr_ready", bus.trans_ready_o, 1);
        tx_q.push_back({1'b1, 16'hD000});
        b_q.push_back(4'h9);
        tick();
        // Last RX beat and 5th read in the same cycle: read must wait.
        issue(1'b0, 2'b01, 8'd0);
        rx_beat(0, 16'hC000, 1'b1, "full_pop");
        check("same_cycle_ready", bus.trans_ready_o, 0);
        tick();
        bus.phy_rx_valid_i = '0;
        settle();
        check("next_cycle_ready", bus.trans_ready_o, 1);
        rx_q.push_back({1'b1, 16'hC004});
        tick();
        bus.trans_valid_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            rx_beat(0, 16'hC000 + 16'(i), 1'b1, "drain");
            tick();
        end
        bus.phy_rx_valid_i = '0;
        tx_beat("drain_tx");
        tick();
        bus.tx_valid_i = 1'b0;
        bus.phy_b_i[1] = 4'h9;
        bus.phy_b_valid_i = 2'b10;
        settle();
        b_expect("drain_b");
        tick();
        quiet();
        settle();
        check("drain_idle", bus.idle_o, 1);

        // Chip-select corner cases, held off by PHY ready.
        bus.phy_trans_ready_i = 2'b00;
        issue(1'b0, 2'b00, 8'd0);
        settle();
        check("cs0_phy_valid", bus.phy_trans_valid_o, 2'b01);
        check("cs0_phy_cs", bus.phy_trans_cs_o, 2'b00);
        check("cs0_ready", bus.trans_ready_o, 0);
        issue(1'b0, 2'b11, 8'd0);
        settle();
        check("cs3_phy_valid", bus.phy_trans_valid_o, 2'b01);
        check("cs3_phy_cs", bus.phy_trans_cs_o, 2'b01);
        tick();
        quiet();

        // Reset in the middle of a 3-beat write.
        issue(1'b1, 2'b01, 8'd2);
        tick();
        bus.trans_valid_i = 1'b0;
        bus.tx_i = 16'hE000;
        bus.tx_valid_i = 1'b1;
        settle();
        check("mid_tx_valid", bus.phy_tx_valid_o, 2'b01);
        tick();
        bus.phy_b_valid_i = 2'b11;
        bus.phy_rx_valid_i = 2'b11;
        rst_n = 1'b0;
        settle();
        check_quiet_outputs("in_reset");
        tick();
        rst_n = 1'b1;
        settle();
        check_quiet_outputs("after_reset");
        tick();
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
